can_fd_rx_fifo: RTL and testbench

- Frame-oriented receive FIFO for the CAN FD receiver. It sits between the bit-stream/acceptance-filter stage and the host register interface.
- Data width, data depth and info (frame-descriptor) depth are parametrised. It holds FD frames of up to 64 data bytes.
- New behaviour: frame commit/abort, so a frame killed by a bus error leaves no trace. Overrun frames are collapsed to a zero-length descriptor.
- The host reads the head frame by word offset and frees it with release_buffer.

---
 rtl/can_fifo_pkg.sv | 20 ++
 rtl/can_fifo_info_queue.sv | 53 +++++
 rtl/can_fd_rx_fifo.sv | 121 ++++++++++++
 tb/tb_can_fd_rx_fifo.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/can_fifo_pkg.sv
// Shared types and helpers for the CAN FD receive FIFO.
// A frame descriptor holds the word count and the overrun marker of one committed frame.
package can_fifo_pkg;

  // Widest length field carried in a descriptor; supports DEPTH up to 32768 words.
  localparam int unsigned LEN_W = 16;

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic             ovr;
  } can_fifo_desc_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/can_fifo_info_queue.sv
// Descriptor queue for committed frames.
// A push and a pop in the same cycle are accepted even when the queue is full.
module can_fifo_info_queue
  import can_fifo_pkg::*;
#(
  parameter int unsigned  DEPTH = 32,
  localparam int unsigned IW    = clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           push,
  input  can_fifo_desc_t din,
  input  logic           pop,
  output can_fifo_desc_t head,
  output logic [IW:0]    cnt,
  output logic           empty,
  output logic           full
);

  can_fifo_desc_t mem [DEPTH];
  logic [IW-1:0]  wr_idx;
  logic [IW-1:0]  rd_idx;
  logic           do_push;
  logic           do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (IW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_idx] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx <= '0;
      rd_idx <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_idx <= '0;
      rd_idx <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_idx <= wr_idx + IW'(1);
      if (do_pop)  rd_idx <= rd_idx + IW'(1);
      cnt <= cnt + (IW+1)'(do_push) - (IW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/can_fd_rx_fifo.sv
// Frame-oriented CAN FD receive FIFO with commit/abort and per-frame descriptors.
// Words of the frame in progress stay pending until committed, so an abort leaves no trace.
module can_fd_rx_fifo
  import can_fifo_pkg::*;
#(
  parameter int unsigned  DATA_W     = 32,
  parameter int unsigned  DEPTH      = 128,
  parameter int unsigned  INFO_DEPTH = 32,
  localparam int unsigned AW         = clog2(DEPTH),
  localparam int unsigned IW         = clog2(INFO_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reset_mode,
  input  logic              wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              frame_end,
  input  logic              frame_abort,
  input  logic              release_buffer,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] data_out,
  output logic [AW:0]       frame_len,
  output logic              overrun,
  output logic              info_empty,
  output logic [IW:0]       info_cnt,
  output logic [AW:0]       fifo_cnt,
  output logic              desc_lost
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr, fs_ptr, wr_ptr;
  logic [AW:0]       pend_cnt, com_cnt;
  logic              ovr_latch;

  logic              full, wr_ok, wr_drop, rel, commit, slot_ok;
  logic              good, push, rewind, lost;
  logic [AW:0]       wr_len;
  logic              info_full;
  can_fifo_desc_t    head, push_desc;

  assign fifo_cnt  = com_cnt + pend_cnt;
  assign frame_len = info_empty ? '0 : (AW+1)'(head.len);
  assign overrun   = info_empty ? 1'b0 : head.ovr;

  // Commit decision: a release in the same cycle frees a descriptor slot.
  always_comb begin
    full           = (fifo_cnt == (AW+1)'(DEPTH));
    wr_ok          = wr & ~full;
    wr_drop        = wr & full;
    wr_len         = pend_cnt + (AW+1)'(wr_ok);
    rel            = release_buffer & ~info_empty;
    commit         = frame_end & ~frame_abort;
    slot_ok        = ~info_full | rel;
    good           = commit & slot_ok & ~(ovr_latch | wr_drop);
    push           = commit & slot_ok;
    lost           = commit & ~slot_ok;
    rewind         = frame_abort | (commit & ~good);
    push_desc.len  = '0;
    push_desc.ovr  = 1'b0;
    if (good) push_desc.len = LEN_W'(wr_len);
    else      push_desc.ovr = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !reset_mode) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      fs_ptr    <= '0;
      wr_ptr    <= '0;
      pend_cnt  <= '0;
      com_cnt   <= '0;
      ovr_latch <= 1'b0;
      desc_lost <= 1'b0;
      data_out  <= '0;
    end else if (reset_mode) begin
      rd_ptr    <= '0;
      fs_ptr    <= '0;
      wr_ptr    <= '0;
      pend_cnt  <= '0;
      com_cnt   <= '0;
      ovr_latch <= 1'b0;
      desc_lost <= 1'b0;
      data_out  <= '0;
    end else begin
      data_out <= mem[rd_ptr + rd_addr];
      if (rel) rd_ptr <= rd_ptr + AW'(frame_len);
      com_cnt <= com_cnt - (rel ? frame_len : '0) + (good ? wr_len : '0);
      if (rewind) begin
        wr_ptr   <= fs_ptr;
        pend_cnt <= '0;
      end else if (good) begin
        wr_ptr   <= wr_ptr + AW'(wr_ok);
        fs_ptr   <= wr_ptr + AW'(wr_ok);
        pend_cnt <= '0;
      end else begin
        wr_ptr   <= wr_ptr + AW'(wr_ok);
        pend_cnt <= wr_len;
      end
      if (frame_end || frame_abort) ovr_latch <= 1'b0;
      else if (wr_drop)             ovr_latch <= 1'b1;
      if (lost) desc_lost <= 1'b1;
    end
  end

  can_fifo_info_queue #(.DEPTH(INFO_DEPTH)) u_info (
    .clk   (clk),
    .rst   (rst),
    .clr   (reset_mode),
    .push  (push),
    .din   (push_desc),
    .pop   (rel),
    .head  (head),
    .cnt   (info_cnt),
    .empty (info_empty),
    .full  (info_full)
  );

endmodule

// File: tb/tb_can_fd_rx_fifo.sv
// Directed bench for can_fd_rx_fifo: commit, abort, overrun collapse, descriptor loss,
// wrap-around and controller reset, with hand-computed expected values.
module tb_can_fd_rx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        reset_mode;
  logic        wr;
  logic [31:0] data_in;
  logic        frame_end;
  logic        frame_abort;
  logic        release_buffer;
  logic [6:0]  rd_addr;
  logic [31:0] data_out;
  logic [7:0]  frame_len;
  logic        overrun;
  logic        info_empty;
  logic [5:0]  info_cnt;
  logic [7:0]  fifo_cnt;
  logic        desc_lost;

  int n_checks = 0;
  int n_pass   = 0;

  can_fd_rx_fifo dut (
    .clk            (clk),
    .rst            (rst),
    .reset_mode     (reset_mode),
    .wr             (wr),
    .data_in        (data_in),
    .frame_end      (frame_end),
    .frame_abort    (frame_abort),
    .release_buffer (release_buffer),
    .rd_addr        (rd_addr),
    .data_out       (data_out),
    .frame_len      (frame_len),
    .overrun        (overrun),
    .info_empty     (info_empty),
    .info_cnt       (info_cnt),
    .fifo_cnt       (fifo_cnt),
    .desc_lost      (desc_lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] d);
    wr = 1'b1;
    data_in = d;
    step();
    wr = 1'b0;
  endtask

  task automatic commit();
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
  endtask

  task automatic release_head();
    release_buffer = 1'b1;
    step();
    release_buffer = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [6:0] a, input logic [31:0] exp);
    rd_addr = a;
    step();
    check(tag, 64'(data_out), 64'(exp));
  endtask

  initial begin
    rst = 1'b1;
    reset_mode = 1'b0;
    wr = 1'b0;
    data_in = '0;
    frame_end = 1'b0;
    frame_abort = 1'b0;
    release_buffer = 1'b0;
    rd_addr = '0;
    step();
    step();
    rst = 1'b0;
    step();

    check("rst_data_out", 64'(data_out), 64'(0));
    check("rst_frame_len", 64'(frame_len), 64'(0));
    check("rst_overrun", 64'(overrun), 64'(0));
    check("rst_info_empty", 64'(info_empty), 64'(1));
    check("rst_info_cnt", 64'(info_cnt), 64'(0));
    check("rst_fifo_cnt", 64'(fifo_cnt), 64'(0));
    check("rst_desc_lost", 64'(desc_lost), 64'(0));

    // Five-word frame.
    for (int i = 0; i < 5; i++) put(32'hA0 + 32'(i));
    check("f5_pending_cnt", 64'(fifo_cnt), 64'(5));
    check("f5_info_empty_pend", 64'(info_empty), 64'(1));
    commit();
    check("f5_info_cnt", 64'(info_cnt), 64'(1));
    check("f5_frame_len", 64'(frame_len), 64'(5));
    check("f5_fifo_cnt", 64'(fifo_cnt), 64'(5));
    for (int i = 0; i < 5; i++) rd_check("f5_read", 7'(i), 32'hA0 + 32'(i));
    release_head();
    check("f5_rel_empty", 64'(info_empty), 64'(1));
    check("f5_rel_fifo_cnt", 64'(fifo_cnt), 64'(0));

    // Aborted frame, then a 2-word frame whose last word rides with frame_end.
    for (int i = 0; i < 3; i++) put(32'hDEAD0 + 32'(i));
    check("ab_pending", 64'(fifo_cnt), 64'(3));
    frame_abort = 1'b1;
    step();
    frame_abort = 1'b0;
    check("ab_fifo_cnt", 64'(fifo_cnt), 64'(0));
    check("ab_info_cnt", 64'(info_cnt), 64'(0));
    put(32'hB0);
    wr = 1'b1;
    data_in = 32'hB1;
    frame_end = 1'b1;
    step();
    wr = 1'b0;
    frame_end = 1'b0;
    check("ab_frame_len", 64'(frame_len), 64'(2));
    check("ab_fifo_cnt2", 64'(fifo_cnt), 64'(2));
    rd_check("ab_read0", 7'd0, 32'hB0);
    rd_check("ab_read1", 7'd1, 32'hB1);
    release_head();

    // Overrun: 120-word frame, then 10 words of which only 8 fit.
    for (int i = 0; i < 120; i++) put(32'h1000 + 32'(i));
    commit();
    for (int i = 0; i < 10; i++) put(32'h2000 + 32'(i));
    check("ov_full_cnt", 64'(fifo_cnt), 64'(128));
    commit();
    check("ov_info_cnt", 64'(info_cnt), 64'(2));
    check("ov_fifo_cnt", 64'(fifo_cnt), 64'(120));
    check("ov_first_len", 64'(frame_len), 64'(120));
    check("ov_first_ovr", 64'(overrun), 64'(0));
    rd_check("ov_read119", 7'd119, 32'h1000 + 32'd119);
    release_head();
    check("ov_second_len", 64'(frame_len), 64'(0));
    check("ov_second_ovr", 64'(overrun), 64'(1));
    check("ov_rel_fifo_cnt", 64'(fifo_cnt), 64'(0));
    release_head();
    check("ov_empty", 64'(info_empty), 64'(1));
    check("ov_empty_ovr", 64'(overrun), 64'(0));

    // Descriptor queue full: one more commit is lost.
    for (int i = 0; i < 32; i++) begin
      put(32'(i));
      commit();
    end
    check("dl_info_cnt_full", 64'(info_cnt), 64'(32));
    check("dl_desc_lost_pre", 64'(desc_lost), 64'(0));
    put(32'hEE);
    commit();
    check("dl_desc_lost", 64'(desc_lost), 64'(1));
    check("dl_info_cnt", 64'(info_cnt), 64'(32));
    check("dl_fifo_cnt", 64'(fifo_cnt), 64'(32));
    put(32'h77);
    release_buffer = 1'b1;
    frame_end = 1'b1;
    step();
    release_buffer = 1'b0;
    frame_end = 1'b0;
    check("dl_relcommit_info", 64'(info_cnt), 64'(32));
    check("dl_relcommit_fifo", 64'(fifo_cnt), 64'(32));
    rd_check("dl_head_after_rel", 7'd0, 32'd1);
    for (int i = 0; i < 31; i++) release_head();
    check("dl_last_info", 64'(info_cnt), 64'(1));
    check("dl_last_len", 64'(frame_len), 64'(1));
    rd_check("dl_last_data", 7'd0, 32'h77);
    release_head();
    check("dl_drain_fifo", 64'(fifo_cnt), 64'(0));

    // Wrap-around across the buffer boundary.
    for (int it = 0; it < 10; it++) begin
      for (int w = 0; w < 20; w++) put(32'(it * 256 + w));
      commit();
      check("wr_frame_len", 64'(frame_len), 64'(20));
      rd_check("wr_read0", 7'd0, 32'(it * 256));
      rd_check("wr_read10", 7'd10, 32'(it * 256 + 10));
      rd_check("wr_read19", 7'd19, 32'(it * 256 + 19));
      release_head();
      check("wr_fifo_zero", 64'(fifo_cnt), 64'(0));
    end

    // Controller reset mid-frame.
    for (int i = 0; i < 4; i++) put(32'h3000 + 32'(i));
    put(32'h3004);
    commit();
    for (int i = 0; i < 4; i++) put(32'h4000 + 32'(i));
    reset_mode = 1'b1;
    step();
    reset_mode = 1'b0;
    check("rm_fifo_cnt", 64'(fifo_cnt), 64'(0));
    check("rm_info_cnt", 64'(info_cnt), 64'(0));
    check("rm_info_empty", 64'(info_empty), 64'(1));
    check("rm_desc_lost", 64'(desc_lost), 64'(0));
    check("rm_data_out", 64'(data_out), 64'(0));
    put(32'hC0);
    put(32'hC1);
    put(32'hC2);
    commit();
    check("rm_frame_len", 64'(frame_len), 64'(3));
    rd_check("rm_read0", 7'd0, 32'hC0);
    rd_check("rm_read2", 7'd2, 32'hC2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
